// File: rtl/uart_flood_checker.sv
`default_nettype none
// ============================================================================
//  Module      : uart_flood_checker
//  Description : 8N1 UART receiver that checks the received bytes form a
//                modulo-256 incrementing sequence. It reports each byte,
//                pulses on framing and sequence errors, and keeps saturating
//                counters of good frames and of errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_flood_checker #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  data,
    output logic        avail,
    output logic        frame_err,
    output logic        seq_err,
    output logic        locked,
    output logic [15:0] rx_count,
    output logic [15:0] err_count
);

    localparam int             c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_clk_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_sync_meta;
    logic                 r_rx_s;
    logic [1:0]           r_primed;
    logic [7:0]           r_expected;
    logic [7:0]           r_data;
    logic                 r_avail;
    logic                 r_frame_err;
    logic                 r_seq_err;
    logic                 r_locked;
    logic [15:0]          r_rx_count;
    logic [15:0]          r_err_count;

    logic                 w_clk_clr;
    logic                 w_bit_clr;
    logic                 w_sample;
    logic                 w_good;
    logic                 w_bad;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Two-flop synchronizer for the asynchronous line. r_primed marks when
    // rx_s reflects a real line sample rather than the flops' reset value,
    // so a line held low through reset is never mistaken for idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= 1'b1;
            r_rx_s      <= 1'b1;
            r_primed    <= 2'b00;
        end else begin
            r_sync_meta <= rx;
            r_rx_s      <= r_sync_meta;
            r_primed    <= {r_primed[0], 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_next = r_state;
        w_clk_clr    = 1'b0;
        w_bit_clr    = 1'b0;
        w_sample     = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        case (r_state)
            ST_WAIT_IDLE: begin
                w_clk_clr = 1'b1;
                if (r_primed[1] && r_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_clk_clr = 1'b1;
                if (!r_rx_s) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_clk_cnt == c_HALF_LAST) begin
                    w_clk_clr = 1'b1;
                    if (r_rx_s) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_bit_clr    = 1'b1;
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_clr = 1'b1;
                    w_sample  = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_clr = 1'b1;
                    if (r_rx_s) begin
                        w_good       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_bad        = 1'b1;
                        w_state_next = ST_WAIT_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_WAIT_IDLE;
            end
        endcase
    end

    // Bit-timing counter, bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_clk_cnt <= w_clk_clr ? '0 : r_clk_cnt + 1'b1;
            if (w_bit_clr) begin
                r_bit_idx <= 3'd0;
            end else if (w_sample) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_sample) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
        end
    end

    // Byte output, sequence check, error pulses and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= 8'd0;
            r_avail     <= 1'b0;
            r_frame_err <= 1'b0;
            r_seq_err   <= 1'b0;
            r_locked    <= 1'b0;
            r_expected  <= 8'd0;
            r_rx_count  <= 16'd0;
            r_err_count <= 16'd0;
        end else begin
            r_avail     <= 1'b0;
            r_frame_err <= 1'b0;
            r_seq_err   <= 1'b0;
            if (w_good) begin
                r_data     <= r_shift;
                r_avail    <= 1'b1;
                r_rx_count <= sat_inc(r_rx_count);
                r_expected <= r_shift + 8'd1;
                r_locked   <= 1'b1;
                // The first byte after reset only establishes the sequence.
                if (r_locked && (r_shift != r_expected)) begin
                    r_seq_err   <= 1'b1;
                    r_err_count <= sat_inc(r_err_count);
                end
            end else if (w_bad) begin
                r_frame_err <= 1'b1;
                r_err_count <= sat_inc(r_err_count);
            end
        end
    end

    assign data      = r_data;
    assign avail     = r_avail;
    assign frame_err = r_frame_err;
    assign seq_err   = r_seq_err;
    assign locked    = r_locked;
    assign rx_count  = r_rx_count;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_flood_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_flood_checker
//  Description : Scoreboard bench for uart_flood_checker. Stimulus pushes the
//                expected event for each frame; a monitor pops and compares
//                whenever the DUT pulses avail, frame_err or seq_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_flood_checker;

    localparam int c_CPB = 16;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [7:0]  data;
    logic        avail;
    logic        frame_err;
    logic        seq_err;
    logic        locked;
    logic [15:0] rx_count;
    logic [15:0] err_count;

    typedef struct {
        bit         ferr;
        logic [7:0] d;
        bit         serr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    uart_flood_checker #(.CLKS_PER_BIT(c_CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .avail     (avail),
        .frame_err (frame_err),
        .seq_err   (seq_err),
        .locked    (locked),
        .rx_count  (rx_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every output event must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (avail || frame_err || seq_err) begin
            check("event_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
                check("avail", {31'd0, avail}, {31'd0, !e.ferr});
                if (!e.ferr) begin
                    check("data", {24'd0, data}, {24'd0, e.d});
                    check("seq_err", {31'd0, seq_err}, {31'd0, e.serr});
                    check("locked_on_avail", {31'd0, locked}, 32'd1);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        idle(10);
    endtask

    // Drives one 8N1 frame; a low stop bit leaves the line low afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [7:0] v;
        v  = b;
        rx = 1'b0;
        idle(c_CPB);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            idle(c_CPB);
        end
        rx = stop;
        idle(c_CPB);
        rx = stop;
    endtask

    task automatic send_good(input logic [7:0] b, input bit serr);
        exp_t e;
        e.ferr = 1'b0;
        e.d    = b;
        e.serr = serr;
        sb.push_back(e);
        send_frame(b, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        check(name, sb.size(), 0);
    endtask

    task automatic check_counts(input string name, input logic [15:0] rc, input logic [15:0] ec);
        check({name, "_rx_count"}, {16'd0, rx_count}, {16'd0, rc});
        check({name, "_err_count"}, {16'd0, err_count}, {16'd0, ec});
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        rst = 1'b0;
        // Reset state
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_avail", {31'd0, avail}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_seq_err", {31'd0, seq_err}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check_counts("rst", 16'd0, 16'd0);
        idle(10);

        // Contiguous incrementing stream 0..9
        for (int i = 0; i < 10; i++) begin
            send_good(8'(i), 1'b0);
        end
        wait_drain("drain_inc");
        check("inc_locked", {31'd0, locked}, 32'd1);
        check_counts("inc", 16'd10, 16'd0);

        // Sequence break and resync
        do_reset();
        send_good(8'h05, 1'b0);
        send_good(8'h06, 1'b0);
        send_good(8'h09, 1'b1);
        send_good(8'h0A, 1'b0);
        wait_drain("drain_seq");
        check_counts("seq", 16'd4, 16'd1);

        // Wrap-around
        do_reset();
        send_good(8'hFE, 1'b0);
        send_good(8'hFF, 1'b0);
        send_good(8'h00, 1'b0);
        send_good(8'h01, 1'b0);
        wait_drain("drain_wrap");
        check_counts("wrap", 16'd4, 16'd0);

        // Framing error, line held low, then recovery
        do_reset();
        e.ferr = 1'b1;
        e.d    = 8'h00;
        e.serr = 1'b0;
        sb.push_back(e);
        send_frame(8'h55, 1'b0);
        idle(40);
        rx = 1'b1;
        idle(20);
        wait_drain("drain_ferr");
        check("ferr_data_kept", {24'd0, data}, 32'd0);
        check("ferr_locked", {31'd0, locked}, 32'd0);
        check_counts("ferr", 16'd0, 16'd1);
        send_good(8'h56, 1'b0);
        wait_drain("drain_after_ferr");
        check_counts("after_ferr", 16'd1, 16'd1);

        // Short glitch on idle line
        do_reset();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check_counts("glitch", 16'd0, 16'd0);
        check("glitch_locked", {31'd0, locked}, 32'd0);
        send_good(8'h33, 1'b0);
        wait_drain("drain_glitch");
        check_counts("after_glitch", 16'd1, 16'd0);

        // Reset mid-frame with line held low
        rx = 1'b0;
        idle(c_CPB * 5 + c_CPB / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(200);
        check("midrst_data", {24'd0, data}, 32'd0);
        check("midrst_locked", {31'd0, locked}, 32'd0);
        check_counts("midrst", 16'd0, 16'd0);
        rx = 1'b1;
        idle(20);
        send_good(8'h10, 1'b0);
        wait_drain("drain_midrst");
        check("midrst_relock", {31'd0, locked}, 32'd1);
        check_counts("after_midrst", 16'd1, 16'd0);

        idle(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_flood_checker.md
Name: uart_flood_checker

Overview:
- UART receive-side checker for the integer flood stream: recovers 8N1 bytes from a serial line and verifies they form a modulo-256 incrementing sequence.
- Exposes each received byte, per-event error pulses and saturating statistics counters.
- Sits at the far end of the serial link, on-chip for loopback or on a second board, as the self-checking consumer of the flooder's output.

Parameters:
- CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200 baud, truncated); minimum legal value 4.

Ports:
- clk  input  1  system clock, all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial input, idle high
- data  output  8  last correctly framed byte
- avail  output  1  one-cycle pulse; data is valid in that cycle and stays stable until the next pulse
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- seq_err  output  1  one-cycle pulse: framed byte differs from expected value
- locked  output  1  high once the first good byte after reset has been received
- rx_count  output  16  good frames received, saturating at 16'hFFFF
- err_count  output  16  frame_err plus seq_err events, saturating at 16'hFFFF

Behaviour:
- Reset values:
  - data=0, avail=0, frame_err=0, seq_err=0, locked=0, rx_count=0, err_count=0.
  - Expected value=0, both synchronizer flops=1, FSM=WAIT_IDLE, bit/clock counters=0.
- Reset asserted mid-frame abandons the frame immediately; no pulses are emitted for it.
- rx passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s, adding 2 cycles of input latency.
- FSM states:
  - WAIT_IDLE: stay until rx_s==1 for one cycle, then go to IDLE. Prevents a line held low at reset release, or a break, from being taken as a start bit.
  - IDLE: rx_s==0 -> START, clear clock counter.
  - START: count to CLKS_PER_BIT/2-1 (mid-bit).
    - rx_s==1 there: glitch -> IDLE, no pulse, no count.
    - rx_s==0 there: -> DATA, clear clock counter and bit index.
  - DATA: every CLKS_PER_BIT cycles sample rx_s into shift register, LSB first. After bit index 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles sample rx_s.
    - rx_s==1: good frame. Update data, pulse avail the next cycle, -> IDLE.
    - rx_s==0: pulse frame_err, err_count+1, data unchanged, no avail, -> WAIT_IDLE.
- Sequence check, evaluated in the cycle the good byte is latched; its pulses coincide with avail:
  - locked==0: set locked=1, expected=byte+1 (mod 256), no seq_err.
  - locked==1 and byte==expected: expected=byte+1.
  - locked==1 and byte!=expected: pulse seq_err, err_count+1, resync expected=byte+1.
  - 8'hFF followed by 8'h00 is correct (wrap-around, no error).
- rx_count increments on every avail, including mismatched bytes.
- frame_err and seq_err are mutually exclusive per frame, so err_count never needs +2.
- Both counters saturate and never wrap.
- Latency: avail rises CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles (±1) after the rx falling edge of the start bit.
- Back-to-back frames: a new start bit is accepted in the first IDLE cycle after STOP; no inter-frame gap is required beyond the stop bit.

Test Plan:
- Bench at CLKS_PER_BIT=16; drive bytes 0x00..0x09 contiguous 8N1 -> 10 avail pulses, data 0..9 in order, locked=1 after the first, rx_count=10, err_count=0, no seq_err.
- Send 0x05,0x06,0x09,0x0A -> seq_err on the 0x09 avail only, err_count=1, no error on 0x0A (resynced), rx_count=4.
- Send 0xFE,0xFF,0x00,0x01 -> wrap-around accepted, err_count=0.
- Send 0x55 with stop bit driven low, then hold rx low 40 cycles, then idle, then send 0x56:
  - frame_err pulse once, no avail, data keeps its previous value, err_count=1.
  - 0x56 then received normally, with no seq_err if first after reset.
- Low glitch of 4 cycles on idle rx -> FSM returns to IDLE, no pulses, counters unchanged; a following 0x33 is received correctly.
- Assert rst for 1 cycle during bit 4 of a frame with rx held low:
  - all outputs return to 0, locked=0.
  - No start is detected until rx returns high; the next full frame is received with locked=1 afterwards.
